// File: rtl/xalu_ise_req.sv
// Issue/response stage in front of the ISE ALU: registers one custom-instruction request,
// holds it on the ISE port until claimed or timed out, then returns the result over valid/ready.
module xalu_ise_req #(
    parameter int MAX_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             ise_clk,
    input  logic             ise_rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_fn,
    input  logic [6:0]       req_imm,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [4:0]       req_rd,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [4:0]       resp_rd,
    output logic             resp_illegal,
    output logic [5:0]       ise_fn,
    output logic [6:0]       ise_imm,
    output logic [31:0]      ise_in1,
    output logic [31:0]      ise_in2,
    output logic             ise_val,
    input  logic             ise_oval,
    input  logic [31:0]      ise_out,
    output logic [CNT_W-1:0] op_count
);

    localparam int LAT_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MAX_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic [5:0]       fn_q;
    logic [6:0]       imm_q;
    logic [31:0]      in1_q;
    logic [31:0]      in2_q;
    logic [4:0]       rd_q;
    logic [31:0]      data_q;
    logic             illegal_q;
    logic [LAT_W-1:0] lat_cnt_q;
    logic [CNT_W-1:0] op_count_q;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ise_clk) begin
        if (ise_rst) begin
            state_q    <= IDLE;
            fn_q       <= '0;
            imm_q      <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            rd_q       <= '0;
            data_q     <= '0;
            illegal_q  <= 1'b0;
            lat_cnt_q  <= '0;
            op_count_q <= '0;
        end else if (flush) begin
            // Killed op leaves no trace: no response, no count, ISE port idles next cycle.
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        fn_q      <= req_fn;
                        imm_q     <= req_imm;
                        in1_q     <= req_rs1;
                        in2_q     <= req_rs2;
                        rd_q      <= req_rd;
                        lat_cnt_q <= '0;
                        state_q   <= EXEC;
                    end
                end
                EXEC: begin
                    if (ise_oval) begin
                        data_q     <= ise_out;
                        illegal_q  <= 1'b0;
                        op_count_q <= op_count_q + 1'b1;
                        state_q    <= RESP;
                    end else if (lat_cnt_q == LAT_LAST) begin
                        data_q    <= '0;
                        illegal_q <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake flags decode straight from the state register, so they are glitch-free.
    assign req_ready    = (state_q == IDLE);
    assign ise_val      = (state_q == EXEC);
    assign resp_valid   = (state_q == RESP);
    assign resp_data    = data_q;
    assign resp_rd      = rd_q;
    assign resp_illegal = illegal_q;
    assign ise_fn       = fn_q;
    assign ise_imm      = imm_q;
    assign ise_in1      = in1_q;
    assign ise_in2      = in2_q;
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_xalu_ise_req.sv
// Directed bench for xalu_ise_req (MAX_LAT=4, CNT_W=4): legal, unclaimed, backpressure,
// flush and counter-wrap scenarios with hand-computed expectations.
module tb_xalu_ise_req;

    logic        ise_clk;
    logic        ise_rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_fn;
    logic [6:0]  req_imm;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_rd;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_illegal;
    logic [5:0]  ise_fn;
    logic [6:0]  ise_imm;
    logic [31:0] ise_in1;
    logic [31:0] ise_in2;
    logic        ise_val;
    logic        ise_oval;
    logic [31:0] ise_out;
    logic [3:0]  op_count;

    int n_cmp = 0;
    int n_bad = 0;

    xalu_ise_req #(.MAX_LAT(4), .CNT_W(4)) u_dut (
        .ise_clk     (ise_clk),
        .ise_rst     (ise_rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_fn      (req_fn),
        .req_imm     (req_imm),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_rd      (req_rd),
        .flush       (flush),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_rd     (resp_rd),
        .resp_illegal(resp_illegal),
        .ise_fn      (ise_fn),
        .ise_imm     (ise_imm),
        .ise_in1     (ise_in1),
        .ise_in2     (ise_in2),
        .ise_val     (ise_val),
        .ise_oval    (ise_oval),
        .ise_out     (ise_out),
        .op_count    (op_count)
    );

    initial ise_clk = 1'b0;
    always #5 ise_clk = ~ise_clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge ise_clk);
        #1;
    endtask

    task automatic drive_req(input logic [5:0] fn, input logic [6:0] imm,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [4:0] rd);
        req_valid = 1'b1;
        req_fn    = fn;
        req_imm   = imm;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_rd    = rd;
    endtask

    // Legal op, ISE claims in first EXEC cycle, core accepts at once; checks the result.
    task automatic run_legal(input logic [4:0] rd, input logic [31:0] result);
        drive_req(6'h02, 7'h11, 32'h1, 32'h2, rd);
        ise_oval = 1'b1;
        ise_out  = result;
        step();
        req_valid = 1'b0;
        step();
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_data !== result) begin
            n_bad++;
            $display("FAIL run_legal resp: valid=%b data=%h, want valid=1 data=%h",
                     resp_valid, resp_data, result);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        ise_oval   = 1'b0;
    endtask

    task automatic test_reset();
        ise_rst = 1'b1;
        step();
        step();
        ise_rst = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset req_ready: got %b want 1", req_ready);
        end
        n_cmp++;
        if (resp_valid !== 1'b0 || ise_val !== 1'b0) begin
            n_bad++; $display("FAIL reset valids: resp_valid=%b ise_val=%b want 0/0", resp_valid, ise_val);
        end
        n_cmp++;
        if (op_count !== 4'd0 || resp_data !== 32'd0 || ise_in1 !== 32'd0 || resp_illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL reset regs: op_count=%0d resp_data=%h ise_in1=%h illegal=%b want 0",
                     op_count, resp_data, ise_in1, resp_illegal);
        end
    endtask

    // rs1^rs2 = 88888888, plus imm 3 -> 8888888B is the model ISE result.
    task automatic test_legal();
        drive_req(6'h00, 7'h03, 32'h01234567, 32'h89abcdef, 5'd12);
        ise_oval = 1'b1;
        ise_out  = 32'h8888888B;
        step();
        req_valid = 1'b0;
        n_cmp++;
        if (ise_val !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL legal exec flags: ise_val=%b req_ready=%b resp_valid=%b want 1/0/0",
                     ise_val, req_ready, resp_valid);
        end
        n_cmp++;
        if (ise_in1 !== 32'h01234567 || ise_in2 !== 32'h89abcdef || ise_fn !== 6'h00 || ise_imm !== 7'h03) begin
            n_bad++;
            $display("FAIL legal operands: in1=%h in2=%h fn=%h imm=%h want 01234567 89abcdef 00 03",
                     ise_in1, ise_in2, ise_fn, ise_imm);
        end
        step();
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_data !== 32'h8888888B || resp_illegal !== 1'b0 || resp_rd !== 5'd12) begin
            n_bad++;
            $display("FAIL legal resp: valid=%b data=%h illegal=%b rd=%0d want 1 8888888b 0 12",
                     resp_valid, resp_data, resp_illegal, resp_rd);
        end
        n_cmp++;
        if (op_count !== 4'd1) begin
            n_bad++; $display("FAIL legal op_count: got %0d want 1", op_count);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        ise_oval   = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL legal return: req_ready=%b resp_valid=%b want 1/0", req_ready, resp_valid);
        end
    endtask

    task automatic test_unclaimed();
        int cycles = 0;
        ise_oval = 1'b0;
        ise_out  = 32'hDEADBEEF;
        drive_req(6'h01, 7'h00, 32'h5, 32'h6, 5'd7);
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ise_val !== 1'b1) break;
            cycles++;
            step();
        end
        n_cmp++;
        if (cycles != 4) begin
            n_bad++; $display("FAIL unclaimed ise_val cycles: got %0d want 4", cycles);
        end
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_illegal !== 1'b1 || resp_data !== 32'd0 || resp_rd !== 5'd7) begin
            n_bad++;
            $display("FAIL unclaimed resp: valid=%b illegal=%b data=%h rd=%0d want 1 1 0 7",
                     resp_valid, resp_illegal, resp_data, resp_rd);
        end
        n_cmp++;
        if (op_count !== 4'd1) begin
            n_bad++; $display("FAIL unclaimed op_count: got %0d want 1", op_count);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int bad_cycles = 0;
        drive_req(6'h03, 7'h40, 32'hA, 32'hB, 5'd9);
        ise_oval = 1'b1;
        ise_out  = 32'hCAFE0001;
        step();
        step();
        ise_oval = 1'b0;
        ise_out  = 32'h0;
        // req_valid stays high to show nothing is accepted while stalled.
        for (int i = 0; i < 10; i++) begin
            if (resp_valid !== 1'b1 || resp_data !== 32'hCAFE0001 || resp_rd !== 5'd9 ||
                req_ready !== 1'b0 || resp_illegal !== 1'b0)
                bad_cycles++;
            step();
        end
        n_cmp++;
        if (bad_cycles != 0) begin
            n_bad++; $display("FAIL backpressure hold: %0d unstable cycles, want 0", bad_cycles);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || ise_val !== 1'b0) begin
            n_bad++;
            $display("FAIL backpressure release: req_ready=%b resp_valid=%b ise_val=%b want 1/0/0",
                     req_ready, resp_valid, ise_val);
        end
        n_cmp++;
        if (op_count !== 4'd2) begin
            n_bad++; $display("FAIL backpressure op_count: got %0d want 2", op_count);
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        // Flush in EXEC with the ISE claiming the same cycle.
        drive_req(6'h00, 7'h01, 32'h3, 32'h4, 5'd3);
        ise_oval = 1'b0;
        step();
        req_valid = 1'b0;
        ise_oval  = 1'b1;
        ise_out   = 32'h12345678;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1 || ise_val !== 1'b0 || resp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush exec state: req_ready=%b ise_val=%b resp_valid=%b want 1/0/0",
                     req_ready, ise_val, resp_valid);
        end
        for (int i = 0; i < 4; i++) begin
            if (resp_valid === 1'b1) seen++;
            step();
        end
        n_cmp++;
        if (seen != 0 || op_count !== 4'd2) begin
            n_bad++; $display("FAIL flush exec effect: resp seen %0d op_count=%0d want 0/2", seen, op_count);
        end
        // Flush while the response is waiting.
        drive_req(6'h00, 7'h01, 32'h3, 32'h4, 5'd3);
        step();
        req_valid = 1'b0;
        step();
        ise_oval = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b1 || op_count !== 4'd3) begin
            n_bad++; $display("FAIL flush resp setup: resp_valid=%b op_count=%0d want 1/3", resp_valid, op_count);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL flush resp: resp_valid=%b req_ready=%b want 0/1", resp_valid, req_ready);
        end
        // Flush in IDLE blocks acceptance.
        drive_req(6'h02, 7'h02, 32'h7, 32'h8, 5'd1);
        flush = 1'b1;
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        n_cmp++;
        if (ise_val !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL flush idle: ise_val=%b req_ready=%b want 0/1", ise_val, req_ready);
        end
    endtask

    task automatic test_wrap();
        ise_rst = 1'b1;
        step();
        step();
        ise_rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            run_legal(5'(i), 32'h1000 + 32'(i));
        end
        n_cmp++;
        if (op_count !== 4'd1) begin
            n_bad++; $display("FAIL wrap op_count: got %0d want 1", op_count);
        end
    endtask

    initial begin
        ise_rst    = 1'b1;
        req_valid  = 1'b0;
        req_fn     = '0;
        req_imm    = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        req_rd     = '0;
        flush      = 1'b0;
        resp_ready = 1'b0;
        ise_oval   = 1'b0;
        ise_out    = '0;
        test_reset();
        test_legal();
        test_unclaimed();
        test_backpressure();
        test_flush();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
